arq_ctrl: RTL

Stop-and-wait ARQ controller that sequences the ECC-protected FIFO datapath. It accepts one 4-bit word from an upstream source and drives the FIFO write and read strobes. It watches the FIFO's ack/nack response and retransmits the held word on nack or timeout, up to a retry limit. It then either delivers the word downstream over a valid/ready handshake or reports a failure. It sits between the pin-level wrapper and the FIFO+SECDED core.

---
 rtl/arq_ctrl_if.sv | 40 ++++
 rtl/arq_ctrl.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/arq_ctrl_if.sv
// arq_ctrl_if: signal bundle between the ARQ controller and its neighbours:
// the upstream source, the FIFO+SECDED core and the downstream sink.
// The controller connects through the master modport and its environment
// through the slave modport.
interface arq_ctrl_if #(
  parameter int DW        = 4,
  parameter int MAX_RETRY = 3
);
  localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  logic          src_valid;
  logic [DW-1:0] src_data;
  logic          src_ready;
  logic          fifo_wr_en;
  logic [DW-1:0] fifo_data_in;
  logic          fifo_rd_en;
  logic [DW-1:0] fifo_data_out;
  logic          fifo_ack;
  logic          fifo_nack;
  logic          dst_valid;
  logic [DW-1:0] dst_data;
  logic          dst_ready;
  logic          busy;
  logic          word_ok;
  logic          word_fail;
  logic [RW-1:0] retry_cnt;
  logic [7:0]    err_total;

  modport master (
    input  src_valid, src_data, fifo_data_out, fifo_ack, fifo_nack, dst_ready,
    output src_ready, fifo_wr_en, fifo_data_in, fifo_rd_en, dst_valid, dst_data,
           busy, word_ok, word_fail, retry_cnt, err_total
  );

  modport slave (
    output src_valid, src_data, fifo_data_out, fifo_ack, fifo_nack, dst_ready,
    input  src_ready, fifo_wr_en, fifo_data_in, fifo_rd_en, dst_valid, dst_data,
           busy, word_ok, word_fail, retry_cnt, err_total
  );
endinterface

// File: rtl/arq_ctrl.sv
// arq_ctrl: stop-and-wait ARQ sequencer for the ECC-protected FIFO.
// One word is held at a time: written to the FIFO, read back, and either
// delivered on ack or retransmitted on nack/timeout until the retry budget
// is spent, after which the word is dropped and word_fail pulses.
module arq_ctrl #(
  parameter int DW        = 4,
  parameter int MAX_RETRY = 3,
  parameter int TIMEOUT   = 7
) (
  input  logic       clk,
  input  logic       rst,
  arq_ctrl_if.master bus
);
  localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WRITE   = 3'd1,
    S_READ    = 3'd2,
    S_WAIT    = 3'd3,
    S_DELIVER = 3'd4
  } state_t;

  state_t        state_r;
  state_t        next_s;
  logic [DW-1:0] hold_r;
  logic [DW-1:0] deliv_r;
  logic [RW-1:0] retry_r;
  logic [TW-1:0] tmo_r;
  logic [7:0]    err_r;
  logic          word_ok_r;
  logic          word_fail_r;
  logic          src_ready_s;
  logic          accept_s;
  logic          latch_s;
  logic          fail_s;
  logic          retry_left_s;

  // src_ready is held low during reset so no word is taken while rst is high.
  assign src_ready_s  = (state_r == S_IDLE) && !rst;
  assign retry_left_s = (retry_r < RETRY_MAX);

  // Next-state decode; nack outranks ack, and ack outranks a same-cycle timeout.
  always_comb begin
    next_s   = state_r;
    accept_s = 1'b0;
    latch_s  = 1'b0;
    fail_s   = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (bus.src_valid && src_ready_s) begin
          accept_s = 1'b1;
          next_s   = S_WRITE;
        end else begin
          next_s = S_IDLE;
        end
      end
      S_WRITE: next_s = S_READ;
      S_READ:  next_s = S_WAIT;
      S_WAIT: begin
        if (bus.fifo_nack) begin
          fail_s = 1'b1;
          next_s = retry_left_s ? S_WRITE : S_IDLE;
        end else if (bus.fifo_ack) begin
          latch_s = 1'b1;
          next_s  = S_DELIVER;
        end else if (tmo_r == TMO_LAST) begin
          fail_s = 1'b1;
          next_s = retry_left_s ? S_WRITE : S_IDLE;
        end else begin
          next_s = S_WAIT;
        end
      end
      S_DELIVER: begin
        if (bus.dst_ready) begin
          next_s = S_IDLE;
        end else begin
          next_s = S_DELIVER;
        end
      end
      default: next_s = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= next_s;
    end
  end

  // Held/delivered words, retry and error accounting, and status pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_r      <= '0;
      deliv_r     <= '0;
      retry_r     <= '0;
      tmo_r       <= '0;
      err_r       <= 8'd0;
      word_ok_r   <= 1'b0;
      word_fail_r <= 1'b0;
    end else begin
      word_ok_r   <= (state_r == S_DELIVER) && bus.dst_ready;
      word_fail_r <= fail_s && !retry_left_s;
      if (accept_s) begin
        hold_r  <= bus.src_data;
        retry_r <= '0;
      end
      if (state_r == S_READ) begin
        tmo_r <= '0;
      end else if (state_r == S_WAIT) begin
        tmo_r <= tmo_r + TW'(1);
      end
      if (latch_s) begin
        deliv_r <= bus.fifo_data_out;
      end
      if (fail_s) begin
        if (err_r != 8'hFF) begin
          err_r <= err_r + 8'd1;
        end
        if (retry_left_s) begin
          retry_r <= retry_r + RW'(1);
        end
      end
    end
  end

  assign bus.src_ready    = src_ready_s;
  assign bus.fifo_wr_en   = (state_r == S_WRITE);
  assign bus.fifo_data_in = hold_r;
  assign bus.fifo_rd_en   = (state_r == S_READ);
  assign bus.dst_valid    = (state_r == S_DELIVER);
  assign bus.dst_data     = deliv_r;
  assign bus.busy         = (state_r != S_IDLE);
  assign bus.word_ok      = word_ok_r;
  assign bus.word_fail    = word_fail_r;
  assign bus.retry_cnt    = retry_r;
  assign bus.err_total    = err_r;
endmodule
